rv_sdram_bridge: RTL and testbench
==================================

// Module: rv_sdram_bridge
// PURPOSE
//  Upstream adapter between the RISC-V softcore's 32-bit valid/ready memory bus and the
//  16-bit rv_* port of the SNES SDRAM controller. Splits each word access into one or two
//  half-word slots aligned to clkref periods. Retries a slot when the controller reports
//  rv_wait because CPU/BSRAM traffic took priority. Assembles read data and returns mem_ready.
// PARAMETERS
//  SKIP_EMPTY_HALF  1   1: a write half with zero byte strobes issues no slot
//  RETRY_W          16  width of the saturating retry counter
// PORTS
//  clk          in   1   SDRAM clock (same clock as the SDRAM controller)
//  resetn       in   1   synchronous, active-low reset
//  clkref       in   1   slot reference; one SDRAM slot per rising edge
//  sdram_busy   in   1   controller init/config busy; no slot is issued while high
//  mem_valid    in   1   core request; held high until mem_ready
//  mem_ready    out  1   1-clk pulse: access complete
//  mem_addr     in   21  word address [22:2]
//  mem_wdata    in   32  write data
//  mem_wstrb    in   4   byte strobes; 4'b0000 = read
//  mem_rdata    out  32  read data, valid when mem_ready is high
//  rv_addr      out  22  half-word address [22:1] to the controller
//  rv_din       out  16  write half-word
//  rv_ds        out  2   byte enables for the half
//  rv_rd/rv_wr  out  1   slot request (at most one high)
//  rv_wait      in   1   0 at slot end = half served
//  rv_dout      in   16  read half-word; stable at slot end
//  retry_cnt    out  RETRY_W  saturating count of rv_wait retries
// BEHAVIOUR
//  - Edge detection: edge = clkref & ~clkref_r, with clkref_r registered on clk.
//    All rv_* outputs change only on the clk where edge=1, then stay stable for the whole slot.
//  - Reset values: mem_ready=0, mem_rdata=0, rv_rd=rv_wr=0, rv_addr=0, rv_din=0, rv_ds=0,
//    retry_cnt=0, state=IDLE, issued=0. Reset mid-access drops the access.
//    The controller may still complete a slot that was already sampled; that is accepted.
//  - States: IDLE, LO, HI, RESP.
//  - IDLE, entry to an access:
//    - Condition: mem_valid & ~mem_ready.
//    - Latch addr, wdata, wstrb.
//    - Go to LO, or straight to HI when SKIP_EMPTY_HALF=1, the access is a write and wstrb[1:0]=0.
//  - LO/HI half contents:
//    - rv_addr = {addr,1'b0} for LO, {addr,1'b1} for HI.
//    - Write: rv_din = wdata half, rv_ds = wstrb half.
//    - Read: rv_ds = 2'b11.
//  - LO/HI on edge, issue rule:
//    - If issued=0 and ~sdram_busy: drive rv_rd/rv_wr and set issued=1.
//    - If sdram_busy: keep both low and stay in the current state.
//  - LO/HI on edge with issued=1, served check:
//    - rv_wait=0 (served):
//      - Read LO captures rv_dout into rdata[15:0]; read HI captures it into rdata[31:16].
//      - Then advance: LO goes to HI, or to RESP when HI is skipped (write, wstrb[3:2]=0).
//        HI goes to RESP.
//      - On the advancing edge the next half is issued directly, so back-to-back slots have no idle slot.
//    - rv_wait=1 (not served):
//      - Re-present the same half and increment retry_cnt, saturating at all-ones.
//  - RESP: mem_ready=1 for exactly one clk with mem_rdata, then return to IDLE.
//    A new access can be accepted no earlier than the clk after mem_ready.
//  - Leaving LO/HI for RESP: rv_rd=rv_wr=0 and issued=0.
//  - Latency in clkref slots, assuming no retries:
//    - Full word read or write: 2 slots plus 1 clk.
//    - Single-half write: 1 slot plus 1 clk.
//  - A write with mem_wstrb=4'b0000 cannot occur, because that encoding means read.
//  - mem_valid dropping before mem_ready is a protocol violation; the bridge completes the access anyway.
// STRUCTURE
//  - Shared package sdram_pkg:
//    - state enum for IDLE/LO/HI/RESP.
//    - RV_ADDR_W = 22.
//    - The half-select encoding.
//  - One sub-module, clkref_edge:
//    - Registers clkref and outputs the edge pulse.
//    - Reused by the other clkref-slot clients.
//  - Everything else sits in one always block.
// TESTING
//  Controller behavioural model: samples rv_* 2 clk after the edge and returns rv_wait/rv_dout before the next edge.
//  1. Read at addr 0x000100, model data 0x1234 (LO) then 0xABCD (HI)
//     -> rv_addr 0x000200 then 0x000201; mem_rdata=0xABCD1234; mem_ready on the 2nd edge +1 clk.
//  2. Write 0xDEADBEEF with wstrb 1111 -> two rv_wr slots: din 0xBEEF ds 11, then din 0xDEAD ds 11.
//  3. Write with wstrb 1100 (SKIP_EMPTY_HALF=1) -> only the HI slot, din=data[31:16], ds=11;
//     mem_ready after 1 slot.
//  4. Model forces rv_wait=1 for 3 slots on the LO half of a read
//     -> LO re-presented 3 times unchanged; retry_cnt=3; correct mem_rdata at the end.
//  5. sdram_busy=1 while mem_valid is high -> rv_rd/rv_wr stay 0. After busy falls, the first
//     request appears on the next edge.
//  6. resetn low mid-HI -> next clk: rv_rd=0, mem_ready=0, state=IDLE. No mem_ready is ever produced
//     for the aborted access.

Source files
------------

// File: rtl/rv_sdram_bridge_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_pkg : shared types for the clkref-slot SDRAM clients            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sdram_pkg;

   localparam int RV_ADDR_W = 22;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   typedef enum logic {
      HALF_LO = 1'b0,
      HALF_HI = 1'b1
   } half_t;

   function automatic logic [RV_ADDR_W-1:0] half_addr(input logic [RV_ADDR_W-2:0] word_addr,
                                                      input half_t half);
      return {word_addr, logic'(half)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv_sdram_bridge_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rv_sdram_bridge_if : core memory bus plus controller rv_* slot port    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface rv_sdram_bridge_if;
   import sdram_pkg::*;

   logic                 mem_valid;
   logic                 mem_ready;
   logic [RV_ADDR_W-2:0] mem_addr;
   logic [31:0]          mem_wdata;
   logic [3:0]           mem_wstrb;
   logic [31:0]          mem_rdata;

   logic [RV_ADDR_W-1:0] rv_addr;
   logic [15:0]          rv_din;
   logic [1:0]           rv_ds;
   logic                 rv_rd;
   logic                 rv_wr;
   logic                 rv_wait;
   logic [15:0]          rv_dout;

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata,
      output rv_addr, rv_din, rv_ds, rv_rd, rv_wr,
      input  rv_wait, rv_dout
   );

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata,
      input  rv_addr, rv_din, rv_ds, rv_rd, rv_wr,
      output rv_wait, rv_dout
   );

endinterface
`default_nettype wire

// File: rtl/rv_sdram_bridge_clkref_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | clkref_edge : one-clk pulse on each rising edge of the slot reference |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module clkref_edge (
   input  wire  clk,
   input  wire  resetn,
   input  wire  clkref,
   output logic clkref_rise
);

   logic r_clkref;

   always_ff @(posedge clk) begin
      if (!resetn) r_clkref <= 1'b0;
      else         r_clkref <= clkref;
   end

   assign clkref_rise = clkref & ~r_clkref;

endmodule
`default_nettype wire

// File: rtl/rv_sdram_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rv_sdram_bridge : 32-bit core bus to 16-bit SDRAM rv_* slot adapter   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rv_sdram_bridge
   import sdram_pkg::*;
#(
   parameter bit SKIP_EMPTY_HALF = 1'b1,
   parameter int RETRY_W         = 16
) (
   input  wire                 clk,
   input  wire                 resetn,
   input  wire                 clkref,
   input  wire                 sdram_busy,
   rv_sdram_bridge_if.slave    bus,
   output logic [RETRY_W-1:0]  retry_cnt
);

   logic w_edge;

   clkref_edge u_clkref_edge (
      .clk         (clk),
      .resetn      (resetn),
      .clkref      (clkref),
      .clkref_rise (w_edge)
   );

   state_t               r_state,     w_state;
   logic                 r_issued,    w_issued;
   logic [RV_ADDR_W-2:0] r_addr,      w_addr;
   logic [31:0]          r_wdata,     w_wdata;
   logic [3:0]           r_wstrb,     w_wstrb;
   logic [31:0]          r_rdata,     w_rdata;
   logic                 r_mem_ready, w_mem_ready;
   logic [31:0]          r_mem_rdata, w_mem_rdata;
   logic [RV_ADDR_W-1:0] r_rv_addr,   w_rv_addr;
   logic [15:0]          r_rv_din,    w_rv_din;
   logic [1:0]           r_rv_ds,     w_rv_ds;
   logic                 r_rv_rd,     w_rv_rd;
   logic                 r_rv_wr,     w_rv_wr;
   logic [RETRY_W-1:0]   r_retry,     w_retry;

   logic  w_is_read;
   logic  w_skip_hi;
   logic  w_issue;
   half_t w_issue_half;
   half_t w_cur_half;

   assign w_is_read  = (r_wstrb == 4'b0000);
   assign w_skip_hi  = SKIP_EMPTY_HALF && !w_is_read && (r_wstrb[3:2] == 2'b00);
   assign w_cur_half = (r_state == ST_HI) ? HALF_HI : HALF_LO;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_issued    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_rdata     <= '0;
         r_mem_ready <= 1'b0;
         r_mem_rdata <= '0;
         r_rv_addr   <= '0;
         r_rv_din    <= '0;
         r_rv_ds     <= '0;
         r_rv_rd     <= 1'b0;
         r_rv_wr     <= 1'b0;
         r_retry     <= '0;
      end else begin
         r_state     <= w_state;
         r_issued    <= w_issued;
         r_addr      <= w_addr;
         r_wdata     <= w_wdata;
         r_wstrb     <= w_wstrb;
         r_rdata     <= w_rdata;
         r_mem_ready <= w_mem_ready;
         r_mem_rdata <= w_mem_rdata;
         r_rv_addr   <= w_rv_addr;
         r_rv_din    <= w_rv_din;
         r_rv_ds     <= w_rv_ds;
         r_rv_rd     <= w_rv_rd;
         r_rv_wr     <= w_rv_wr;
         r_retry     <= w_retry;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_issued     = r_issued;
      w_addr       = r_addr;
      w_wdata      = r_wdata;
      w_wstrb      = r_wstrb;
      w_rdata      = r_rdata;
      w_mem_ready  = r_mem_ready;
      w_mem_rdata  = r_mem_rdata;
      w_rv_addr    = r_rv_addr;
      w_rv_din     = r_rv_din;
      w_rv_ds      = r_rv_ds;
      w_rv_rd      = r_rv_rd;
      w_rv_wr      = r_rv_wr;
      w_retry      = r_retry;
      w_issue      = 1'b0;
      w_issue_half = HALF_LO;

      case (r_state)
         ST_IDLE: begin
            if (bus.mem_valid && !r_mem_ready) begin
               w_addr  = bus.mem_addr;
               w_wdata = bus.mem_wdata;
               w_wstrb = bus.mem_wstrb;
               w_rdata = '0;
               if (SKIP_EMPTY_HALF && (bus.mem_wstrb != 4'b0000) && (bus.mem_wstrb[1:0] == 2'b00))
                  w_state = ST_HI;
               else
                  w_state = ST_LO;
            end
         end

         ST_LO, ST_HI: begin
            if (w_edge) begin
               if (!r_issued) begin
                  if (!sdram_busy) begin
                     w_issue      = 1'b1;
                     w_issue_half = w_cur_half;
                  end
               end else if (!bus.rv_wait) begin
                  if (w_is_read) begin
                     if (r_state == ST_LO) w_rdata[15:0]  = bus.rv_dout;
                     else                  w_rdata[31:16] = bus.rv_dout;
                  end
                  if ((r_state == ST_LO) && !w_skip_hi) begin
                     // Chain straight into the high half so the two slots are adjacent.
                     w_state = ST_HI;
                     if (!sdram_busy) begin
                        w_issue      = 1'b1;
                        w_issue_half = HALF_HI;
                     end else begin
                        w_rv_rd  = 1'b0;
                        w_rv_wr  = 1'b0;
                        w_issued = 1'b0;
                     end
                  end else begin
                     w_state     = ST_RESP;
                     w_rv_rd     = 1'b0;
                     w_rv_wr     = 1'b0;
                     w_issued    = 1'b0;
                     w_mem_ready = 1'b1;
                     w_mem_rdata = w_rdata;
                  end
               end else begin
                  if (r_retry != {RETRY_W{1'b1}}) w_retry = r_retry + 1'b1;
                  // Busy during a retry withdraws the request until the controller is free.
                  if (sdram_busy) begin
                     w_rv_rd  = 1'b0;
                     w_rv_wr  = 1'b0;
                     w_issued = 1'b0;
                  end
               end
            end
         end

         ST_RESP: begin
            w_mem_ready = 1'b0;
            w_state     = ST_IDLE;
         end

         default: w_state = ST_IDLE;
      endcase

      if (w_issue) begin
         w_rv_addr = half_addr(r_addr, w_issue_half);
         w_rv_din  = (w_issue_half == HALF_HI) ? r_wdata[31:16] : r_wdata[15:0];
         w_rv_ds   = w_is_read ? 2'b11 :
                     ((w_issue_half == HALF_HI) ? r_wstrb[3:2] : r_wstrb[1:0]);
         w_rv_rd   = w_is_read;
         w_rv_wr   = !w_is_read;
         w_issued  = 1'b1;
      end
   end

   assign bus.mem_ready = r_mem_ready;
   assign bus.mem_rdata = r_mem_rdata;
   assign bus.rv_addr   = r_rv_addr;
   assign bus.rv_din    = r_rv_din;
   assign bus.rv_ds     = r_rv_ds;
   assign bus.rv_rd     = r_rv_rd;
   assign bus.rv_wr     = r_rv_wr;
   assign retry_cnt     = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_rv_sdram_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_rv_sdram_bridge : directed bench with a slot-level controller model|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_rv_sdram_bridge;
   import sdram_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        clkref = 1'b0;
   logic        sdram_busy = 1'b0;
   logic [15:0] retry_cnt;
   int          ref_cnt = 0;

   int n_checks = 0;
   int n_fail   = 0;
   int force_wait = 0;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [21:0] addr;
      logic [15:0] din;
      logic [1:0]  ds;
   } slot_t;
   slot_t slot_q[$];

   rv_sdram_bridge_if bus_if ();

   rv_sdram_bridge #(.SKIP_EMPTY_HALF(1'b1), .RETRY_W(16)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .clkref     (clkref),
      .sdram_busy (sdram_busy),
      .bus        (bus_if),
      .retry_cnt  (retry_cnt)
   );

   always #5 clk = ~clk;

   // clkref: one clk high every 8 clks, changing on the falling edge
   always @(negedge clk) begin
      ref_cnt = (ref_cnt + 1) % 8;
      clkref  = (ref_cnt == 0);
   end

   function automatic logic [15:0] model_rd(input logic [21:0] a);
      case (a)
         22'h000200: return 16'h1234;
         22'h000201: return 16'hABCD;
         22'h0002AA: return 16'h5A5A;
         22'h0002AB: return 16'hC3C3;
         22'h0003FE: return 16'h0F0F;
         22'h0003FF: return 16'hF0F0;
         default:    return 16'hDEAD;
      endcase
   endfunction

   function automatic logic [25:0] slot_key(input slot_t s);
      return {s.rd, s.wr, s.addr, s.ds};
   endfunction

   // Controller model: sample 2 clk after each slot edge, answer before the next one
   initial begin
      bus_if.rv_wait = 1'b0;
      bus_if.rv_dout = 16'h0000;
      forever begin
         @(posedge clk);
         if (clkref) begin
            repeat (2) @(posedge clk);
            #1;
            if (bus_if.rv_rd || bus_if.rv_wr) begin
               slot_q.push_back({bus_if.rv_rd, bus_if.rv_wr, bus_if.rv_addr, bus_if.rv_din, bus_if.rv_ds});
               if (force_wait > 0) begin
                  bus_if.rv_wait = 1'b1;
                  force_wait--;
               end else begin
                  bus_if.rv_wait = 1'b0;
                  if (bus_if.rv_rd) bus_if.rv_dout = model_rd(bus_if.rv_addr);
               end
            end else begin
               bus_if.rv_wait = 1'b0;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_edge();
      do @(posedge clk); while (!clkref);
      #1;
   endtask

   task automatic run_access(input string tag, input logic [20:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rdata, output int edges);
      logic got;
      got   = 1'b0;
      rdata = '0;
      edges = 0;
      wait_edge();
      bus_if.mem_addr  = a;
      bus_if.mem_wdata = d;
      bus_if.mem_wstrb = s;
      bus_if.mem_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk);
         #1;
         if (clkref) edges++;
         if (bus_if.mem_ready) begin
            got   = 1'b1;
            rdata = bus_if.mem_rdata;
         end
      end
      bus_if.mem_valid = 1'b0;
      check_eq({tag, "_done"}, 64'(got), 64'd1);
   endtask

   initial begin
      logic [31:0] rd;
      int          ed;
      logic        saw;

      bus_if.mem_valid = 1'b0;
      bus_if.mem_addr  = '0;
      bus_if.mem_wdata = '0;
      bus_if.mem_wstrb = '0;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready",  64'(bus_if.mem_ready), 64'd0);
      check_eq("rst_rdata",  64'(bus_if.mem_rdata), 64'd0);
      check_eq("rst_rd",     64'(bus_if.rv_rd),     64'd0);
      check_eq("rst_wr",     64'(bus_if.rv_wr),     64'd0);
      check_eq("rst_addr",   64'(bus_if.rv_addr),   64'd0);
      check_eq("rst_din",    64'(bus_if.rv_din),    64'd0);
      check_eq("rst_ds",     64'(bus_if.rv_ds),     64'd0);
      check_eq("rst_retry",  64'(retry_cnt),        64'd0);
      check_eq("rst_state",  64'(dut.r_state),      64'(ST_IDLE));
      resetn = 1'b1;

      // 1: full-word read
      slot_q.delete();
      run_access("t1", 21'h000100, 32'h0, 4'b0000, rd, ed);
      check_eq("t1_rdata", 64'(rd), 64'hABCD1234);
      check_eq("t1_edges", 64'(ed), 64'd3);
      check_eq("t1_nslot", 64'(slot_q.size()), 64'd2);
      check_eq("t1_slot0", 64'(slot_key(slot_q[0])), 64'({1'b1, 1'b0, 22'h000200, 2'b11}));
      check_eq("t1_slot1", 64'(slot_key(slot_q[1])), 64'({1'b1, 1'b0, 22'h000201, 2'b11}));

      // 2: full-word write
      slot_q.delete();
      run_access("t2", 21'h000080, 32'hDEADBEEF, 4'b1111, rd, ed);
      check_eq("t2_edges", 64'(ed), 64'd3);
      check_eq("t2_nslot", 64'(slot_q.size()), 64'd2);
      check_eq("t2_slot0", 64'(slot_q[0]), 64'({1'b0, 1'b1, 22'h000100, 16'hBEEF, 2'b11}));
      check_eq("t2_slot1", 64'(slot_q[1]), 64'({1'b0, 1'b1, 22'h000101, 16'hDEAD, 2'b11}));

      // 3: upper-half-only write skips the low slot
      slot_q.delete();
      run_access("t3", 21'h000040, 32'h55667788, 4'b1100, rd, ed);
      check_eq("t3_edges", 64'(ed), 64'd2);
      check_eq("t3_nslot", 64'(slot_q.size()), 64'd1);
      check_eq("t3_slot0", 64'(slot_q[0]), 64'({1'b0, 1'b1, 22'h000081, 16'h5566, 2'b11}));

      // 4: three rv_wait retries on the low half of a read
      slot_q.delete();
      force_wait = 3;
      run_access("t4", 21'h000155, 32'h0, 4'b0000, rd, ed);
      check_eq("t4_rdata", 64'(rd), 64'hC3C35A5A);
      check_eq("t4_edges", 64'(ed), 64'd6);
      check_eq("t4_retry", 64'(retry_cnt), 64'd3);
      check_eq("t4_nslot", 64'(slot_q.size()), 64'd5);
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("t4_lo%0d", i), 64'(slot_key(slot_q[i])), 64'({1'b1, 1'b0, 22'h0002AA, 2'b11}));
      check_eq("t4_hi", 64'(slot_key(slot_q[4])), 64'({1'b1, 1'b0, 22'h0002AB, 2'b11}));

      // 5: busy holds off the first request until the edge after it clears
      slot_q.delete();
      wait_edge();
      sdram_busy       = 1'b1;
      bus_if.mem_addr  = 21'h0001FF;
      bus_if.mem_wdata = 32'h0;
      bus_if.mem_wstrb = 4'b0000;
      bus_if.mem_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_edge();
         check_eq($sformatf("t5_busy%0d", i), 64'(bus_if.rv_rd | bus_if.rv_wr), 64'd0);
      end
      sdram_busy = 1'b0;
      wait_edge();
      check_eq("t5_rd",   64'(bus_if.rv_rd),   64'd1);
      check_eq("t5_addr", 64'(bus_if.rv_addr), 64'h0003FE);
      saw = 1'b0;
      for (int i = 0; i < 200 && !saw; i++) begin
         @(posedge clk);
         #1;
         if (bus_if.mem_ready) begin
            saw = 1'b1;
            rd  = bus_if.mem_rdata;
         end
      end
      bus_if.mem_valid = 1'b0;
      check_eq("t5_done",  64'(saw), 64'd1);
      check_eq("t5_rdata", 64'(rd),  64'hF0F00F0F);

      // 6: reset in the middle of the high half drops the access
      wait_edge();
      bus_if.mem_addr  = 21'h000100;
      bus_if.mem_wstrb = 4'b0000;
      bus_if.mem_valid = 1'b1;
      wait_edge();
      wait_edge();
      check_eq("t6_hi_rd",   64'(bus_if.rv_rd),   64'd1);
      check_eq("t6_hi_addr", 64'(bus_if.rv_addr), 64'h000201);
      resetn           = 1'b0;
      bus_if.mem_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("t6_rd",    64'(bus_if.rv_rd),     64'd0);
      check_eq("t6_ready", 64'(bus_if.mem_ready), 64'd0);
      check_eq("t6_state", 64'(dut.r_state),      64'(ST_IDLE));
      check_eq("t6_retry", 64'(retry_cnt),        64'd0);
      resetn = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk);
         #1;
         if (bus_if.mem_ready) saw = 1'b1;
      end
      check_eq("t6_no_ready", 64'(saw), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
